apb_gpio_slave: RTL and testbench

- APB completer (slave) for the GPIO port; sits behind the APB master bridge on the PSEL line that selects GPIO.
- Decodes APB setup/access phases and inserts a programmable number of wait states via PREADY.
- Services a small register file: output data, direction, synchronized input, interrupt enable and status.
- Drives the pad-side output/enable signals and a level interrupt.

---
 rtl/apb_gpio_pkg.sv | 24 ++
 rtl/gpio_sync_edge.sv | 36 +++
 rtl/apb_gpio_slave.sv | 177 +++++++++++++++++
 tb/tb_apb_gpio_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared constants and types for the APB GPIO completer: register offsets,
// data width and the transfer FSM state encoding.
package apb_gpio_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IN       = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Offsets above IRQ_STAT have no register behind them and flag PSLVERR.
  function automatic logic addr_unmapped(input logic [2:0] addr);
    return (addr > ADDR_IRQ_STAT);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop synchronizer for the asynchronous pad inputs, followed by a
// rising-edge detector on the synchronized bus.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise_edge
);

  logic [WIDTH-1:0] stage_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
      prev_r <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      prev_r <= stage_r[SYNC_STAGES-1];
    end
  end

  assign sync_in   = stage_r[SYNC_STAGES-1];
  assign rise_edge = sync_in & ~prev_r;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB completer for the GPIO port: transfer FSM with programmable wait
// states, register file, read mux, pad drive and level interrupt.
module apb_gpio_slave
  import apb_gpio_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_r, state_nxt_s;
  logic [3:0]        wcnt_r, wcnt_nxt_s;
  logic              latch_s;
  logic [2:0]        addr_r;
  logic              write_r;
  logic [DATA_W-1:0] wdata_r;

  logic [DATA_W-1:0] out_r, dir_r, ien_r, istat_r;
  logic [DATA_W-1:0] prdata_r;
  logic              pslverr_r;
  logic              irq_r;

  logic [DATA_W-1:0] sync_in_s, edge_s, in_val_s;
  logic [DATA_W-1:0] rd_data_s, w1c_s;
  logic [2:0]        rd_addr_s;
  logic              rd_err_s, done_entry_s, commit_s, ready_s;
  logic              paddr_unused_s;

  assign paddr_unused_s = ^PADDR[7:3];

  gpio_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (DATA_W)
  ) u_sync_edge (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .async_in  (gpio_in),
    .sync_in   (sync_in_s),
    .rise_edge (edge_s)
  );

  // Next-state and wait-counter logic; PSEL dropping mid-transfer aborts.
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    latch_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          latch_s     = 1'b1;
          wcnt_nxt_s  = WAIT_INIT;
          state_nxt_s = (WAIT_INIT == 4'd0) ? ST_DONE : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_nxt_s = ST_IDLE;
        end else if (wcnt_r <= 4'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          wcnt_nxt_s  = wcnt_r - 4'd1;
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counter and captured setup-phase fields.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      wcnt_r  <= 4'd0;
      addr_r  <= 3'd0;
      write_r <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
      if (latch_s) begin
        addr_r  <= PADDR[2:0];
        write_r <= PWRITE;
        wdata_r <= PWDATA;
      end
    end
  end

  // With zero wait states DONE is entered straight from the setup cycle,
  // before addr_r is loaded, so the mux looks at PADDR directly then.
  assign rd_addr_s    = (state_r == ST_IDLE) ? PADDR[2:0] : addr_r;
  assign done_entry_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
  assign in_val_s     = (dir_r & out_r) | (~dir_r & sync_in_s);

  // Read mux over the register file.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    rd_err_s  = 1'b0;
    case (rd_addr_s)
      ADDR_OUT:      rd_data_s = out_r;
      ADDR_DIR:      rd_data_s = dir_r;
      ADDR_IN:       rd_data_s = in_val_s;
      ADDR_IRQ_EN:   rd_data_s = ien_r;
      ADDR_IRQ_STAT: rd_data_s = istat_r;
      default: begin
        rd_data_s = {DATA_W{1'b0}};
        rd_err_s  = addr_unmapped(rd_addr_s);
      end
    endcase
  end

  // Response registers are loaded on DONE entry and cleared otherwise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prdata_r  <= {DATA_W{1'b0}};
      pslverr_r <= 1'b0;
    end else if (done_entry_s) begin
      prdata_r  <= rd_data_s;
      pslverr_r <= rd_err_s;
    end else begin
      prdata_r  <= {DATA_W{1'b0}};
      pslverr_r <= 1'b0;
    end
  end

  assign commit_s = (state_r == ST_DONE) && PSEL && PENABLE && write_r;
  assign w1c_s    = (commit_s && (addr_r == ADDR_IRQ_STAT)) ? wdata_r : {DATA_W{1'b0}};

  // Register file; a new edge beats a same-cycle W1C clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      out_r   <= {DATA_W{1'b0}};
      dir_r   <= {DATA_W{1'b0}};
      ien_r   <= {DATA_W{1'b0}};
      istat_r <= {DATA_W{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      if (commit_s) begin
        case (addr_r)
          ADDR_OUT:    out_r <= wdata_r;
          ADDR_DIR:    dir_r <= wdata_r;
          ADDR_IRQ_EN: ien_r <= wdata_r;
          default:     ;
        endcase
      end
      istat_r <= (istat_r & ~w1c_s) | edge_s;
      irq_r   <= |(istat_r & ien_r);
    end
  end

  assign ready_s  = (state_r == ST_DONE) && PSEL;
  assign PREADY   = ready_s;
  assign PRDATA   = ready_s ? prdata_r : {DATA_W{1'b0}};
  assign PSLVERR  = ready_s & pslverr_r;
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Scoreboard bench for apb_gpio_slave: two instances (0 and 3 wait states)
// driven by a transfer task against a register-level reference model.
module tb_apb_gpio_slave;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       psel [2], penable [2], pwrite [2];
  logic [7:0] paddr [2], pwdata [2], prdata [2];
  logic       pready [2], pslverr [2], irq [2];
  logic [7:0] gpio_out [2], gpio_oe [2];
  logic [7:0] gpio_in;

  always #5 PCLK = ~PCLK;

  apb_gpio_slave #(.WAIT_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .gpio_in(gpio_in),
    .gpio_out(gpio_out[0]), .gpio_oe(gpio_oe[0]), .irq(irq[0]));

  apb_gpio_slave #(.WAIT_CYCLES(3), .SYNC_STAGES(2)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .gpio_in(gpio_in),
    .gpio_out(gpio_out[1]), .gpio_oe(gpio_oe[1]), .irq(irq[1]));

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       chk_data;
  } exp_t;

  exp_t q0[$], q1[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: register contents per instance plus settled pad value.
  logic [7:0] out_m [2], dir_m [2], ien_m [2], stat_m [2];
  logic [7:0] gin_m;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      out_m[i] = 8'h00; dir_m[i] = 8'h00; ien_m[i] = 8'h00; stat_m[i] = 8'h00;
    end
  endtask

  function automatic logic [7:0] model_rd(input int i, input logic [2:0] a);
    case (a)
      3'd0:    return out_m[i];
      3'd1:    return dir_m[i];
      3'd2:    return (dir_m[i] & out_m[i]) | (~dir_m[i] & gin_m);
      3'd3:    return ien_m[i];
      3'd4:    return stat_m[i];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_wr(input int i, input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0:    out_m[i] = d;
      3'd1:    dir_m[i] = d;
      3'd3:    ien_m[i] = d;
      3'd4:    stat_m[i] = stat_m[i] & ~d;
      default: ;
    endcase
  endtask

  // Pad change followed by enough cycles for sync + edge + irq to settle.
  task automatic set_gpio(input logic [7:0] v);
    logic [7:0] rise;
    rise    = v & ~gin_m;
    gin_m   = v;
    gpio_in = v;
    repeat (5) tick();
    stat_m[0] = stat_m[0] | rise;
    stat_m[1] = stat_m[1] | rise;
  endtask

  // One APB transfer; called at posedge+1 so the setup cycle starts now.
  task automatic xfer(input int i, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    int   n;
    e.data     = model_rd(i, addr[2:0]);
    e.err      = (addr[2:0] >= 3'd5);
    e.chk_data = !wr;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (wr) model_wr(i, addr[2:0], data);
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = wr; paddr[i] = addr; pwdata[i] = data;
    tick();
    penable[i] = 1'b1;
    n = 1;
    @(negedge PCLK);
    while (pready[i] !== 1'b1 && n < 20) begin
      @(posedge PCLK);
      #1;
      n++;
      @(negedge PCLK);
    end
    check_int($sformatf("latency dut%0d", i), n, (i == 0) ? 1 : 4);
    @(posedge PCLK);
    #1;
    psel[i] = 1'b0; penable[i] = 1'b0;
  endtask

  task automatic check_pins();
    for (int i = 0; i < 2; i++) begin
      check8($sformatf("gpio_out dut%0d", i), gpio_out[i], out_m[i]);
      check8($sformatf("gpio_oe dut%0d", i), gpio_oe[i], dir_m[i]);
      check8($sformatf("irq dut%0d", i), {7'd0, irq[i]}, {7'd0, |(stat_m[i] & ien_m[i])});
    end
  endtask

  // Monitor: pops an expectation whenever an instance completes a transfer.
  always @(negedge PCLK) begin : monitor
    exp_t e;
    bit   got;
    if (PRESETn === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (pready[i] === 1'b1) begin
          got = 1'b0;
          if (i == 0 && q0.size() > 0) begin
            e = q0.pop_front(); got = 1'b1;
          end else if (i == 1 && q1.size() > 0) begin
            e = q1.pop_front(); got = 1'b1;
          end
          if (!got) begin
            checks++; failures++;
            $display("FAIL unexpected_pready dut%0d: got PREADY=1 expected no transfer", i);
          end else begin
            if (e.chk_data) check8($sformatf("prdata dut%0d", i), prdata[i], e.data);
            check8($sformatf("pslverr dut%0d", i), {7'd0, pslverr[i]}, {7'd0, e.err});
          end
        end else begin
          check8($sformatf("prdata_idle dut%0d", i), prdata[i], 8'h00);
          check8($sformatf("pslverr_idle dut%0d", i), {7'd0, pslverr[i]}, 8'h00);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h00; pwdata[i] = 8'h00;
    end
    gpio_in = 8'h00;
    gin_m   = 8'h00;
    model_reset();
    PRESETn = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check8($sformatf("rst prdata dut%0d", i), prdata[i], 8'h00);
      check8($sformatf("rst pready dut%0d", i), {7'd0, pready[i]}, 8'h00);
    end
    check_pins();
    PRESETn = 1'b1;
    tick();

    // Zero-wait write then read of OUT.
    xfer(0, 1'b1, 8'h00, 8'hA5);
    check8("gpio_out after write", gpio_out[0], 8'hA5);
    xfer(0, 1'b0, 8'h00, 8'h00);

    // Three-wait write/read of DIR.
    xfer(1, 1'b1, 8'h01, 8'h0F);
    xfer(1, 1'b0, 8'h01, 8'h00);
    tick();
    check_pins();

    // Back-to-back transfers with no idle cycle in between.
    xfer(0, 1'b1, 8'h01, 8'h3C);
    xfer(0, 1'b0, 8'h01, 8'h00);
    xfer(0, 1'b0, 8'h00, 8'h00);
    xfer(1, 1'b1, 8'h03, 8'h81);
    xfer(1, 1'b0, 8'h03, 8'h00);

    // IN mixes OUT for driven bits with synchronized pads for the rest.
    xfer(0, 1'b1, 8'h01, 8'hF0);
    xfer(0, 1'b1, 8'h00, 8'h3C);
    set_gpio(8'h05);
    check8("in model", model_rd(0, 3'd2), 8'h35);
    xfer(0, 1'b0, 8'h02, 8'h00);

    // Interrupt timing: stat after sync+1 cycles, irq one cycle later.
    xfer(0, 1'b1, 8'h03, 8'h01);
    set_gpio(8'h04);
    xfer(0, 1'b1, 8'h04, 8'hFF);
    tick();
    check8("irq cleared", {7'd0, irq[0]}, 8'h00);
    gpio_in = 8'h05; gin_m = 8'h05;
    stat_m[0] = stat_m[0] | 8'h01; stat_m[1] = stat_m[1] | 8'h01;
    repeat (3) tick();
    check8("irq before stat visible", {7'd0, irq[0]}, 8'h00);
    tick();
    check8("irq after edge", {7'd0, irq[0]}, 8'h01);
    xfer(0, 1'b0, 8'h04, 8'h00);
    xfer(0, 1'b1, 8'h04, 8'h01);
    tick();
    check8("irq after w1c", {7'd0, irq[0]}, 8'h00);

    // New edge lands in the W1C commit cycle: the set must win.
    set_gpio(8'h04);
    gpio_in = 8'h05; gin_m = 8'h05;
    tick();
    xfer(0, 1'b1, 8'h04, 8'h01);
    stat_m[0] = stat_m[0] | 8'h01; stat_m[1] = stat_m[1] | 8'h01;
    repeat (2) tick();
    check8("irq set wins", {7'd0, irq[0]}, 8'h01);
    xfer(0, 1'b0, 8'h04, 8'h00);

    // Unmapped offset: zero data, PSLVERR, no register change.
    xfer(0, 1'b0, 8'h06, 8'h00);
    xfer(0, 1'b1, 8'h06, 8'hAB);
    xfer(0, 1'b1, 8'h02, 8'hFF);
    for (int a = 0; a < 5; a++) xfer(0, 1'b0, 8'(a), 8'h00);
    tick();
    check_pins();

    // Abort mid-WAIT: PSEL drops, nothing commits, FSM back in IDLE.
    xfer(1, 1'b1, 8'h00, 8'h5A);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'hFF;
    tick();
    penable[1] = 1'b1;
    tick();
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (6) tick();
    check8("abort gpio_out", gpio_out[1], 8'h5A);
    xfer(1, 1'b0, 8'h00, 8'h00);

    // Randomized traffic against the model.
    for (int k = 0; k < 60; k++) begin
      int ri;
      ri = int'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) set_gpio(8'($urandom));
      xfer(ri, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      tick();
      check_pins();
    end

    // Reset in the middle of transfers acts without a clock edge.
    xfer(0, 1'b1, 8'h00, 8'hC3);
    xfer(0, 1'b1, 8'h01, 8'h81);
    xfer(1, 1'b1, 8'h00, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = 1'b1; paddr[i] = 8'h00; pwdata[i] = 8'h77;
    end
    tick();
    penable[0] = 1'b1; penable[1] = 1'b1;
    #2;
    check8("pready before reset", {7'd0, pready[0]}, 8'h01);
    PRESETn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check8($sformatf("async rst prdata dut%0d", i), prdata[i], 8'h00);
      check8($sformatf("async rst pready dut%0d", i), {7'd0, pready[i]}, 8'h00);
      check8($sformatf("async rst pslverr dut%0d", i), {7'd0, pslverr[i]}, 8'h00);
    end
    check_pins();
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0;
    end
    gpio_in = 8'h00; gin_m = 8'h00;
    repeat (3) tick();
    PRESETn = 1'b1;
    tick();
    xfer(0, 1'b0, 8'h00, 8'h00);
    xfer(1, 1'b0, 8'h00, 8'h00);

    repeat (3) tick();
    check_int("q0 drained", q0.size(), 0);
    check_int("q1 drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
